// File: rtl/mode_select_ctrl.sv
// Mode selector: synchronizes/debounces KEY0, steps a wrapping mode counter per press, drives two 7-seg digits.
// Latency: mode updates DEBOUNCE_CYCLES+3 edges after the press is first sampled; segments follow one edge later.
// Backpressure: none, free-running. Optional auto-repeat while held: define AUTOREPEAT_EN.
module mode_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_MODES       = 12,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_change,
  output logic [3:0] mode,
  output logic       mode_pulse,
  output logic [6:0] segA,
  output logic [6:0] segB
);

  localparam int             CNT_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]     MODE_LAST = 4'(NUM_MODES - 1);
  localparam logic           BTN_IDLE  = BTN_ACTIVE_LOW;
  localparam logic [6:0]     SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic             sync1_q, sync2_q;
  logic             pressed;
  logic             inc;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic [6:0]       seg_a_q, seg_a_d;
  logic [6:0]       seg_b_q, seg_b_d;
  logic [3:0]       tens, units;

`ifdef AUTOREPEAT_EN
  localparam int               RPT_W    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Sync output is in raw button polarity; XOR with the idle level yields 1 = pressed.
  assign pressed = sync2_q ^ BTN_IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
`ifdef AUTOREPEAT_EN
    rpt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          inc     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef AUTOREPEAT_EN
        else if (rpt_q == RPT_LAST) begin
          inc = 1'b1;
        end else begin
          rpt_d = rpt_q + RPT_ONE;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    mode_d  = mode_q;
    if (inc) mode_d = (mode_q == MODE_LAST) ? 4'd0 : mode_q + 4'd1;
    pulse_d = inc;

    // Mode never exceeds 15, so the tens digit is 0 or 1.
    tens    = (mode_q >= 4'd10) ? 4'd1 : 4'd0;
    units   = (mode_q >= 4'd10) ? mode_q - 4'd10 : mode_q;
    seg_a_d = seg7(tens);
    seg_b_d = seg7(units);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BTN_IDLE;
      sync2_q <= BTN_IDLE;
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 4'd0;
      pulse_q <= 1'b0;
      seg_a_q <= SEG_ZERO;
      seg_b_q <= SEG_ZERO;
`ifdef AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync1_q <= btn_change;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
      seg_a_q <= seg_a_d;
      seg_b_q <= seg_b_d;
`ifdef AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign mode       = mode_q;
  assign mode_pulse = pulse_q;
  assign segA       = seg_a_q;
  assign segB       = seg_b_q;

endmodule

// File: doc/mode_select_ctrl.md
Name: mode_select_ctrl

Overview:
- Input-side counterpart of the parameter calculator: it produces the operating mode that the calculator consumes.
- Synchronizes and debounces the raw KEY0 push-button, then advances a wrap-around mode counter (0..NUM_MODES-1) once per confirmed press.
- Flags each mode change with a single-cycle pulse.
- Shows the current mode as two decimal digits on a pair of 7-segment displays.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or release (1 ms at 50 MHz); minimum 2
NUM_MODES, 12, number of modes; mode wraps from NUM_MODES-1 to 0; range 2..16
BTN_ACTIVE_LOW, 1, 1: btn_change pressed = 0 (DE-board KEY); 0: pressed = 1
REPEAT_CYCLES, 25000000, auto-repeat period in cycles; used only with AUTOREPEAT_EN

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
btn_change  input  1  raw asynchronous push-button (KEY0)
mode  output  4  current operating mode, 0..NUM_MODES-1
mode_pulse  output  1  high for exactly one cycle when mode changes
segA  output  7  tens digit of mode, active-low, bit0=a .. bit6=g
segB  output  7  units digit of mode, same encoding

Behaviour:
- Reset (rst_n=0, asynchronous):
  - mode=0, mode_pulse=0, segA=segB=7'b1000000 ("0").
  - FSM in IDLE, debounce counter=0, synchronizer flops hold the released level.
- Input conditioning:
  - Two-flop synchronizer on btn_change, then polarity fix per BTN_ACTIVE_LOW.
  - Result is "pressed" (1 = pressed).
- Debounce FSM (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT); cnt is a counter wide enough for DEBOUNCE_CYCLES-1:
  - IDLE: pressed=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: pressed=0 -> IDLE. Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1 and pressed=1 -> HELD and fire an increment.
  - HELD: pressed=0 -> RELEASE_WAIT, cnt=0. No further increments while held (without AUTOREPEAT_EN).
  - RELEASE_WAIT: pressed=1 -> HELD, with no increment. Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1 -> IDLE.
- Increment:
  - mode <= (mode==NUM_MODES-1) ? 0 : mode+1.
  - mode_pulse=1 in the same cycle the new mode value appears; 0 in all other cycles.
- Latency:
  - The pressed level is sampled by the first synchronizer flop at rising edge 1.
  - mode updates at edge DEBOUNCE_CYCLES+3.
  - segA/segB are registered and update one edge after mode.
- Glitch handling: a bounce shorter than DEBOUNCE_CYCLES cycles in either direction produces no increment and no second increment.
- Display:
  - Tens digit = mode/10, units digit = mode%10, both decimal digits 0..9.
  - A tens digit of 0 displays "0"; it is not blanked.
  - Standard active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset mid-operation: rst_n low in any state forces all outputs and state to reset values immediately; a press held through reset release is seen as a new press.

Optional Feature:
AUTOREPEAT_EN
- Defined: in HELD, a repeat counter runs. Each time it reaches REPEAT_CYCLES-1, one increment fires (mode_pulse high for one cycle) and the repeat counter restarts. The repeat counter clears when HELD is left.
- Undefined: the repeat counter is not present; exactly one increment per accepted press.

Test Plan:
- DEBOUNCE_CYCLES=4, reset then release rst_n -> mode=0, mode_pulse=0, segA=segB=1000000.
- Press held 20 cycles (btn_change=0) -> mode 0->1 at edge 7 after first sampled press; mode_pulse high one cycle; segB=1111001 one edge later; no further change until release.
- Press-release glitch of 2 cycles repeated 5 times -> mode unchanged, mode_pulse never asserted.
- 12 clean presses from mode=0 -> mode steps 1..11 then wraps to 0; at mode=10, segA=1111001 and segB=1000000.
- Assert rst_n=0 mid PRESS_WAIT at mode=5 -> mode=0 immediately; release reset with button held -> one increment after DEBOUNCE_CYCLES+3 edges.
- AUTOREPEAT_EN, REPEAT_CYCLES=8, hold 40 cycles after acceptance -> 5 additional mode_pulse pulses, spaced 8 cycles apart.
